// File: rtl/alu_sequencer_if.sv
// Bundle between the alu_sequencer and its environment: instruction handshake,
// register-file read/write ports, ALU operand/result path and status outputs.
interface alu_sequencer_if;
  // Instruction channel: a word transfers on a rising edge where instr_valid
  // and instr_ready are both 1; the source holds instr stable until then.
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_sel;
  logic [31:0] alu_result;

  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  logic        done;
  logic        illegal;
  logic [31:0] instret;

  // master: the sequencer itself; slave: instruction source, register file and ALU.
  modport master (
    input  instr_valid, instr, rs1_data, rs2_data, alu_result,
    output instr_ready, rs1_addr, rs2_addr, alu_a, alu_b, alu_sel,
           rd_we, rd_addr, rd_data, done, illegal, instret
  );

  modport slave (
    output instr_valid, instr, rs1_data, rs2_data, alu_result,
    input  instr_ready, rs1_addr, rs2_addr, alu_a, alu_b, alu_sel,
           rd_we, rd_addr, rd_data, done, illegal, instret
  );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state sequencer that decodes ADD/SUB/ADDI/ANDI, drives an external
// add/AND ALU from register-file operands and issues a one-cycle write-back.
module alu_sequencer (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.master bus,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADDI = 2'd2,
    OP_ANDI = 2'd3
  } op_t;

  state_t      state;
  op_t         op_q;
  logic [31:0] instr_q;

  logic        dec_legal;
  op_t         dec_op;
  logic [31:0] imm;

  assign fsm_state = state;
  assign imm       = {{20{instr_q[31]}}, instr_q[31:20]};

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    if (instr_q[6:0] == 7'b0110011 && instr_q[14:12] == 3'b000) begin
      if (instr_q[31:25] == 7'b0000000) begin
        dec_legal = 1'b1;
        dec_op    = OP_ADD;
      end else if (instr_q[31:25] == 7'b0100000) begin
        dec_legal = 1'b1;
        dec_op    = OP_SUB;
      end
    end else if (instr_q[6:0] == 7'b0010011) begin
      if (instr_q[14:12] == 3'b000) begin
        dec_legal = 1'b1;
        dec_op    = OP_ADDI;
      end else if (instr_q[14:12] == 3'b111) begin
        dec_legal = 1'b1;
        dec_op    = OP_ANDI;
      end
    end
  end

  // Operands are only driven in EXEC; SUB becomes an add of the negated rs2.
  always_comb begin
    bus.alu_a   = 32'd0;
    bus.alu_b   = 32'd0;
    bus.alu_sel = 1'b0;
    if (state == EXEC) begin
      bus.alu_a = bus.rs1_data;
      case (op_q)
        OP_ADD:  bus.alu_b = bus.rs2_data;
        OP_SUB:  bus.alu_b = ~bus.rs2_data + 32'd1;
        default: bus.alu_b = imm;
      endcase
      bus.alu_sel = (op_q == OP_ANDI);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      op_q            <= OP_ADD;
      instr_q         <= 32'd0;
      bus.instr_ready <= 1'b0;
      bus.rs1_addr    <= 5'd0;
      bus.rs2_addr    <= 5'd0;
      bus.rd_we       <= 1'b0;
      bus.rd_addr     <= 5'd0;
      bus.rd_data     <= 32'd0;
      bus.done        <= 1'b0;
      bus.illegal     <= 1'b0;
      bus.instret     <= 32'd0;
    end else begin
      bus.rd_we   <= 1'b0;
      bus.done    <= 1'b0;
      bus.illegal <= 1'b0;
      case (state)
        IDLE: begin
          // Ready is raised one cycle after reset release or an illegal drop.
          if (!bus.instr_ready) begin
            bus.instr_ready <= 1'b1;
          end else if (bus.instr_valid) begin
            instr_q         <= bus.instr;
            bus.rs1_addr    <= bus.instr[19:15];
            bus.rs2_addr    <= bus.instr[24:20];
            bus.instr_ready <= 1'b0;
            state           <= DECODE;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            op_q  <= dec_op;
            state <= EXEC;
          end else begin
            bus.illegal <= 1'b1;
            bus.done    <= 1'b1;
            state       <= IDLE;
          end
        end
        EXEC: begin
          bus.rd_data <= bus.alu_result;
          bus.rd_addr <= instr_q[11:7];
          bus.rd_we   <= (instr_q[11:7] != 5'd0);
          bus.done    <= 1'b1;
          bus.instret <= bus.instret + 32'd1;
          state       <= WB;
        end
        WB: begin
          bus.instr_ready <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
